// File: rtl/crc32_arbiter.sv
// Round-robin front end for one shared bit-serial crc32 engine: accepts one job at a time,
// sequences engine load/compute, and returns the captured CRC with the requester id.
module crc32_arbiter #(
   parameter int N_REQ          = 4,
   parameter int IDW            = $clog2(N_REQ),
   parameter int COMPUTE_CYCLES = 33
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_REQ-1:0]      req_valid_i,
   output logic [N_REQ-1:0]      req_ready_o,
   input  logic [32*N_REQ-1:0]   req_msg_i,
   input  logic [32*N_REQ-1:0]   req_poly_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [IDW-1:0]        rsp_id_o,
   output logic [31:0]           rsp_crc_o,
   output logic                  eng_rst_no,
   output logic                  eng_compute_o,
   output logic [31:0]           eng_msg_o,
   output logic [31:0]           eng_poly_o,
   input  logic [31:0]           eng_crc_i,
   output logic                  busy_o,
   output logic [15:0]           jobs_done_o
);
   localparam int CW = $clog2(COMPUTE_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, CAPTURE, RESP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     msg_q, msg_d, poly_q, poly_d, crc_q, crc_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [15:0]     jobs_q, jobs_d;
   logic            eng_rst_q, eng_cmp_q;

   logic [31:0]     msg_a  [N_REQ];
   logic [31:0]     poly_a [N_REQ];
   logic            gnt_vld;
   logic [IDW-1:0]  gnt_id;

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign msg_a[i]  = req_msg_i[32*i +: 32];
      assign poly_a[i] = req_poly_i[32*i +: 32];
   end

   // Search starts just past the last winner so every port gets a turn.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!gnt_vld && req_valid_i[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      msg_d       = msg_q;
      poly_d      = poly_q;
      id_d        = id_q;
      crc_d       = crc_q;
      jobs_d      = jobs_q;
      req_ready_o = '0;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               req_ready_o[gnt_id] = 1'b1;
               msg_d   = msg_a[gnt_id];
               poly_d  = poly_a[gnt_id];
               id_d    = gnt_id;
               ptr_d   = gnt_id;
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = CW'(COMPUTE_CYCLES - 1);
            state_d = COMPUTE;
         end
         COMPUTE: begin
            if (cnt_q == '0) state_d = CAPTURE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         CAPTURE: begin
            crc_d   = eng_crc_i;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               jobs_d  = jobs_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Engine controls are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         ptr_q     <= IDW'(N_REQ - 1);
         cnt_q     <= '0;
         msg_q     <= '0;
         poly_q    <= '0;
         id_q      <= '0;
         crc_q     <= '0;
         jobs_q    <= '0;
         eng_rst_q <= 1'b0;
         eng_cmp_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         msg_q     <= msg_d;
         poly_q    <= poly_d;
         id_q      <= id_d;
         crc_q     <= crc_d;
         jobs_q    <= jobs_d;
         eng_rst_q <= (state_d != LOAD);
         eng_cmp_q <= (state_d == COMPUTE);
      end
   end

   assign rsp_valid_o   = (state_q == RESP);
   assign rsp_id_o      = id_q;
   assign rsp_crc_o     = crc_q;
   assign eng_rst_no    = eng_rst_q;
   assign eng_compute_o = eng_cmp_q;
   assign eng_msg_o     = msg_q;
   assign eng_poly_o    = poly_q;
   assign busy_o        = (state_q != IDLE);
   assign jobs_done_o   = jobs_q;

endmodule

// File: tb/tb_crc32_arbiter.sv
// Bench for crc32_arbiter with a counting stub engine and a round-robin reference model.
module tb_crc32_arbiter;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    vmask;
   logic [N-1:0]    req_ready_o;
   logic [32*N-1:0] req_msg, req_poly;
   logic            rsp_valid_o, rsp_ready;
   logic [1:0]      rsp_id_o;
   logic [31:0]     rsp_crc_o;
   logic            eng_rst_no, eng_compute_o;
   logic [31:0]     eng_msg_o, eng_poly_o, eng_crc;
   logic            busy_o;
   logic [15:0]     jobs_done_o;

   logic [31:0]     mmsg [N];
   logic [31:0]     mpoly[N];
   int              m_ptr, m_jobs;
   int              checks = 0, errors = 0;
   int              cyc = 0, comp_seen = 0, scnt = 0;

   always #5 clk = ~clk;

   crc32_arbiter #(.N_REQ(N)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(vmask), .req_ready_o(req_ready_o),
      .req_msg_i(req_msg), .req_poly_i(req_poly),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id_o), .rsp_crc_o(rsp_crc_o),
      .eng_rst_no(eng_rst_no), .eng_compute_o(eng_compute_o),
      .eng_msg_o(eng_msg_o), .eng_poly_o(eng_poly_o), .eng_crc_i(eng_crc),
      .busy_o(busy_o), .jobs_done_o(jobs_done_o)
   );

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign req_msg[32*i +: 32]  = mmsg[i];
      assign req_poly[32*i +: 32] = mpoly[i];
   end

   // Stub engine: result is only meaningful after 33 compute cycles since the last load.
   always @(posedge clk) begin
      if (!eng_rst_no)       scnt <= 0;
      else if (eng_compute_o) scnt <= scnt + 1;
   end
   assign eng_crc = (scnt >= 33) ? (eng_msg_o ^ eng_poly_o) : 32'hDEADDEAD;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (eng_compute_o === 1'b1) comp_seen <= comp_seen + 1;

   always @(negedge clk) begin
      checks++;
      assert (!(eng_compute_o === 1'b1 && eng_rst_no === 1'b0)) else begin
         errors++;
         $error("FAIL compute_in_load: observed compute=%0b rst_n=%0b expected no overlap", eng_compute_o, eng_rst_no);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] m, input int p);
      for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // Entered at a negedge with the DUT idle and vmask nonzero; returns at a negedge after the handshake.
   task automatic run_job(input int d, output int id_obs);
      int eg, t0, c0, n;
      logic bad, bad_bp;
      logic [31:0] exp_crc, h_crc;
      logic [1:0]  h_id;
      rsp_ready = (d == 0);
      #1;
      eg = model_grant(vmask, m_ptr);
      chk("req_ready_grant", {28'd0, req_ready_o}, 32'(1) << eg);
      exp_crc = mmsg[eg] ^ mpoly[eg];
      t0 = cyc;
      c0 = comp_seen;
      @(posedge clk);
      #1;
      vmask[eg] = 1'b0;
      m_ptr = eg;
      bad = 1'b0;
      n = 0;
      while (rsp_valid_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         if (req_ready_o !== '0) bad = 1'b1;
         n++;
      end
      chk("rsp_arrived", {31'd0, rsp_valid_o}, 32'd1);
      chk("latency", 32'(cyc - t0), 32'd36);
      chk("compute_cycles", 32'(comp_seen - c0), 32'd33);
      chk("ready_quiet", {31'd0, bad}, 32'd0);
      chk("rsp_crc", rsp_crc_o, exp_crc);
      chk("busy_resp", {31'd0, busy_o}, 32'd1);
      id_obs = int'(rsp_id_o);
      chk("rsp_id", {30'd0, rsp_id_o}, 32'(eg));
      if (d > 0) begin
         h_crc = rsp_crc_o;
         h_id  = rsp_id_o;
         bad_bp = 1'b0;
         for (int j = 0; j < d; j++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_crc_o !== h_crc || rsp_id_o !== h_id) bad_bp = 1'b1;
            if (req_ready_o !== '0 || eng_compute_o !== 1'b0 || eng_rst_no !== 1'b1) bad_bp = 1'b1;
         end
         chk("backpressure_hold", {31'd0, bad_bp}, 32'd0);
         rsp_ready = 1'b1;
      end
      @(posedge clk);
      m_jobs = (m_jobs + 1) & 32'hFFFF;
      @(negedge clk);
      chk("rsp_dropped", {31'd0, rsp_valid_o}, 32'd0);
      chk("jobs_done", {16'd0, jobs_done_o}, 32'(m_jobs));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      m_ptr  = N - 1;
      m_jobs = 0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd0);
      chk({tag, "_id"}, {30'd0, rsp_id_o}, 32'd0);
      chk({tag, "_crc"}, rsp_crc_o, 32'd0);
      chk({tag, "_eng"}, {30'd0, eng_compute_o, eng_rst_no}, 32'd0);
      chk({tag, "_msg"}, eng_msg_o, 32'd0);
      chk({tag, "_poly"}, eng_poly_o, 32'd0);
      chk({tag, "_jobs"}, {16'd0, jobs_done_o}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int g, c0, n;
      int order[5];
      logic seen_rsp;
      vmask = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin mmsg[i] = 32'd0; mpoly[i] = 32'd0; end
      @(negedge clk);
      do_reset();
      chk_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single job from requester 2
      mmsg[2]  = 32'h12345678;
      mpoly[2] = 32'h04C11DB7;
      vmask = 4'b0100;
      run_job(0, g);
      chk("single_crc", rsp_crc_o, 32'h16F54BCF);

      // all four at once from reset; requester 0 comes back after its first job
      do_reset();
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin mmsg[i] = 32'(i); mpoly[i] = $urandom; end
      vmask = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         run_job(0, order[k]);
         if (k == 0) vmask[0] = 1'b1;
      end
      chk("rr_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0], 12'd0},
          32'h0123_0000);

      // back-pressure for 10 cycles while others keep requesting
      for (int i = 0; i < N; i++) begin mmsg[i] = $urandom; mpoly[i] = $urandom; end
      vmask = 4'b1011;
      run_job(10, g);

      // randomized jobs, masks and response delays
      for (int k = 0; k < 12; k++) begin
         vmask = 4'($urandom_range(1, 15));
         for (int i = 0; i < N; i++) begin mmsg[i] = $urandom; mpoly[i] = $urandom; end
         run_job($urandom_range(0, 4), g);
      end

      // reset in the middle of compute
      vmask = 4'b0010;
      mmsg[1] = $urandom;
      mpoly[1] = $urandom;
      #1;
      c0 = comp_seen;
      @(posedge clk);
      #1;
      vmask = '0;
      n = 0;
      while (comp_seen - c0 < 15 && n < 60) begin @(negedge clk); #1; n++; end
      chk("midjob_reached", 32'(comp_seen - c0), 32'd15);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_state("midrst");
      rst_n = 1'b1;
      m_ptr = N - 1;
      m_jobs = 0;
      seen_rsp = 1'b0;
      repeat (45) begin @(negedge clk); if (rsp_valid_o !== 1'b0) seen_rsp = 1'b1; end
      chk("midrst_no_rsp", {31'd0, seen_rsp}, 32'd0);
      vmask = 4'b1010;
      for (int i = 0; i < N; i++) begin mmsg[i] = $urandom; mpoly[i] = $urandom; end
      run_job(0, g);
      chk("ptr_after_reset", 32'(g), 32'd1);
      vmask = 4'b1000;
      run_job(1, g);

      // jobs counter wrap
      force dut.jobs_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.jobs_q;
      @(negedge clk);
      chk("jobs_preload", {16'd0, jobs_done_o}, 32'h0000FFFF);
      m_jobs = 32'hFFFF;
      vmask = 4'b0001;
      run_job(0, g);
      chk("jobs_wrap", {16'd0, jobs_done_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
